// File: rtl/shared_res_pkg.sv
// Shared types, limits and helpers for the N-channel shared_resource front end.
package shared_res_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned NUM_CH_MAX = 8;

  typedef logic [DEF_DATA_W-1:0]         lane_t;
  typedef logic [$clog2(NUM_CH_MAX)-1:0] ch_idx_t;

  // Round-robin pointer increment, wrapping at num_ch.
  function automatic ch_idx_t idx_next(input ch_idx_t p, input int unsigned num_ch);
    if (32'(p) + 32'd1 >= num_ch) return '0;
    return p + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/shared_resource_rr_n_if.sv
// Client-side bundle of the N-channel front end; clock and reset stay outside.
interface shared_resource_rr_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_flush;
  logic [NUM_CH-1:0]        in_stall;
  logic [NUM_CH-1:0]        out_stall;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_flush;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH*CNT_W-1:0]  out_count;
  logic [NUM_CH-1:0]        out_grant;

  modport master (
    output in_data, in_valid, in_flush, in_stall,
    input  out_stall, out_valid, out_flush, out_data, out_count, out_grant
  );

  modport slave (
    input  in_data, in_valid, in_flush, in_stall,
    output out_stall, out_valid, out_flush, out_data, out_count, out_grant
  );
endinterface

// File: rtl/buffer_slots.sv
// Per-channel skid FIFO with registered full flag and synchronous flush.
module buffer_slots #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              enq_i,
  input  logic              deq_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (32'(p) == DEPTH - 1) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq_i) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      if (enq_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;
endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer it owns.
module rr_arbiter_n
  import shared_res_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] grant_o
);
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef logic [IdxW-1:0] lidx_t;

  lidx_t ptr_q, ptr_d, idx;
  logic  found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = ptr_q;
    ptr_d   = ptr_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = lidx_t'(idx_next(ch_idx_t'(idx), NUM_CH));
      end
      idx = lidx_t'(idx_next(ch_idx_t'(idx), NUM_CH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/shared_resource.sv
// The shared combinational datapath: rotate left by 4, then flip bit 0.
module shared_resource #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  output logic [DATA_W-1:0] y_o
);
  assign y_o = {a_i[DATA_W-5:0], a_i[DATA_W-1 -: 4]} ^ DATA_W'(1);
endmodule

// File: rtl/shared_resource_rr_n.sv
// N-channel front end: per-channel skid FIFOs, round-robin access to one
// shared_resource datapath, registered per-channel result stage.
module shared_resource_rr_n
  import shared_res_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  shared_resource_rr_n_if.slave bus
);
  logic [NUM_CH-1:0]        empty, full, enq, deq, req, ready, grant;
  logic [DATA_W-1:0]        head [NUM_CH];
  logic [DATA_W-1:0]        cand [NUM_CH];
  logic [CNT_W-1:0]         count [NUM_CH];
  logic [NUM_CH*CNT_W-1:0]  count_flat;
  logic [DATA_W-1:0]        res_in, res_out;

  logic [NUM_CH-1:0]        out_valid_q, out_valid_d, out_flush_q, out_flush_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    buffer_slots #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
    ) u_buf (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .flush_i (bus.in_flush[i]),
      .enq_i   (enq[i]),
      .deq_i   (deq[i]),
      .wdata_i (bus.in_data[i*DATA_W +: DATA_W]),
      .rdata_o (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i]),
      .count_o (count[i])
    );
  end

  // Requests are masked by reset_n so the grant reads zero during reset.
  always_comb begin
    count_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand[i]  = empty[i] ? bus.in_data[i*DATA_W +: DATA_W] : head[i];
      ready[i] = !(out_valid_q[i] && bus.in_stall[i]);
      req[i]   = (!empty[i] || bus.in_valid[i]) && ready[i] && !bus.in_flush[i] && reset_n;
      count_flat[i*CNT_W +: CNT_W] = count[i];
    end
  end

  rr_arbiter_n #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .req_i   (req),
    .grant_o (grant)
  );

  always_comb begin
    res_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) res_in = res_in | cand[i];
      deq[i] = grant[i] && !empty[i];
      enq[i] = bus.in_valid[i] && !full[i] && !bus.in_flush[i] && !(grant[i] && empty[i]);
    end
  end

  shared_resource #(
    .DATA_W (DATA_W)
  ) u_res (
    .a_i (res_in),
    .y_o (res_out)
  );

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = '0;
    out_flush_d = bus.in_flush;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.in_flush[i])                          out_valid_d[i] = 1'b0;
      else if (out_valid_q[i] && bus.in_stall[i])   out_valid_d[i] = 1'b1;
      else                                          out_valid_d[i] = grant[i];
      if (grant[i]) out_data_d[i*DATA_W +: DATA_W] = res_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= '0;
      out_flush_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flush_q <= out_flush_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_stall = full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flush = out_flush_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = count_flat;
  assign bus.out_grant = grant;
endmodule

// File: doc/shared_resource_rr_n.md
Name: shared_resource_rr_n

Overview:
N-channel front end for the single combinational shared_resource datapath. Each channel has a parametrised skid FIFO, valid/stall/flush handshakes and a registered output stage. A stall-aware round-robin arbiter picks at most one channel per cycle to use the resource. It generalises the two-channel fixed-priority block to NUM_CH channels, configurable DEPTH and fair arbitration.

Parameters:
NUM_CH, 4, number of client channels (2..8)
DATA_W, 32, data width per channel
DEPTH, 2, per-channel FIFO entries (power of 2, >=1)
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_data  input  NUM_CH*DATA_W  per-channel input data, channel i at [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel input valid
in_flush  input  NUM_CH  per-channel flush request
in_stall  input  NUM_CH  per-channel downstream stall
out_stall  output  NUM_CH  per-channel upstream stall; equals FIFO full
out_valid  output  NUM_CH  per-channel registered result valid
out_flush  output  NUM_CH  per-channel flush acknowledge, registered
out_data  output  NUM_CH*DATA_W  per-channel registered result
out_count  output  NUM_CH*CNT_W  per-channel FIFO occupancy
out_grant  output  NUM_CH  one-hot grant of the current cycle, for debug and coverage

Behaviour:
- Reset (reset_n=0, async): all FIFOs empty, count 0, out_valid=0, out_flush=0, out_data=0, rr pointer=0, out_grant=0.
- Candidate per channel: FIFO head if non-empty, else in_data[i] (bypass).
- req[i] = (!empty[i] | in_valid[i]) & ready[i] & !in_flush[i].
- ready[i] = !(out_valid[i] & in_stall[i]). Stalled channels never win the grant.
- Arbiter: round-robin, one-hot grant, search starts at pointer p. After any grant to channel g, p <= (g+1) mod NUM_CH. With no request, grant=0 and p holds.
- fire[i] = grant[i]. The resource input is the granted candidate. Combinational resource output is captured into out_data[i] on fire.
- Latency: bypass accept to out_valid = 1 cycle. A FIFO entry leaves only when its channel fires.
- enq[i] = in_valid[i] & !full[i] & !in_flush[i] & !(fire[i] & empty[i]).
- deq[i] = fire[i] & !empty[i].
- Simultaneous enq and deq: count unchanged, order preserved (FIFO). Pointers wrap mod DEPTH.
- full[i] is registered (count==DEPTH). When full, in_valid is ignored; upstream must hold data while out_stall=1.
- out_valid[i] next: 0 if in_flush[i]; else 1 if out_valid & in_stall (hold, data held); else fire[i].
- Flush of channel i:
  - FIFO cleared next edge, count 0, out_valid 0, out_flush 1 for exactly one cycle per asserted cycle.
  - Channel i is excluded from arbitration and its input dropped in the flush cycle.
  - Other channels are unaffected.
- Flush wins over a simultaneous stall or valid on the same channel.
- Reset mid-operation: immediate clear of all state, including in-flight FIFO data.
- No combinational path from in_stall to out_stall.

Decomposition:
- Package shared_res_pkg: DATA_W default, NUM_CH_MAX=8, the function idx_next(p,NUM_CH) for pointer wrap, and a typedef for the flattened lane slice.
- Sub-module rr_arbiter_n (parametrised NUM_CH): req vector in, one-hot grant out, owns the pointer.
- Reuse the existing buffer_slots, generalised with DEPTH, and the existing shared_resource.

Test Plan:
- Bypass: ch0 in_valid=1, in_data=0x0000_00A5, all else idle -> next cycle out_valid[0]=1, out_data[0]=f(0xA5), count0 stays 0.
- Fairness: all 4 channels valid every cycle, no stall -> grants cycle 0,1,2,3,0...; each channel gets exactly 25 grants in 100 cycles.
- Backpressure, DEPTH=2:
  - ch1 in_stall held with out_valid[1]=1 while ch1 sends 3 words.
  - -> count1 reaches 2 and out_stall[1]=1; the 3rd word is held upstream.
  - Release stall -> results emerge in order, with no loss or duplication.
- Stall-aware arbitration: ch0 stalled with out_valid[0]=1, ch2 requesting -> ch2 granted every cycle, ch0 never granted until the stall drops.
- Flush: ch3 holds 2 queued words and asserts in_flush[3] for one cycle -> next cycle out_flush[3]=1, out_valid[3]=0, count3=0; ch0 traffic continues uninterrupted.
- Async reset: drop reset_n mid-burst between clock edges -> all outputs 0 immediately; after release, the first grant goes to ch0.
